// File: rtl/ext_bus_arb_pkg.sv
// Shared types and constants for the external bus master arbiter.
package ext_bus_arb_pkg;

    localparam int unsigned MAX_MASTERS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRequest,
        StGrant,
        StRelease
    } ext_arb_state_t;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible requester at or after the pointer wins.
module rr_priority_picker #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] mask,
    input  logic [IDX_W-1:0]       pointer,
    output logic [NUM_MASTERS-1:0] winner_onehot,
    output logic [IDX_W-1:0]       winner_idx,
    output logic                   valid
);

    logic [NUM_MASTERS-1:0] eligible;

    assign eligible = req & ~mask;

    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        valid         = 1'b0;
        // First pass scans pointer..N-1, second pass wraps around to 0..pointer-1.
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!valid && eligible[i] && (i >= 32'(pointer))) begin
                valid            = 1'b1;
                winner_idx       = IDX_W'(i);
                winner_onehot[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!valid && eligible[i] && (i < 32'(pointer))) begin
                valid            = 1'b1;
                winner_idx       = IDX_W'(i);
                winner_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ext_bus_master_arbiter.sv
// Round-robin hold-request arbiter sharing the system bus among external bus masters.
// Define EXT_BUS_ARB_TIMEOUT_EN to force release after MAX_TENURE grant clocks.
module ext_bus_master_arbiter
    import ext_bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS   = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES    = 8,
    parameter int unsigned MAX_TENURE    = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   address_enable_n,
    input  logic [3:0]             dma_acknowledge_n,
    input  logic                   no_command_state,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   ext_access_request,
    output logic                   bus_owned,
    output logic                   timeout_pulse
);

    localparam int unsigned IDX_W    = cnt_width(NUM_MASTERS - 1);
    localparam int unsigned GAP_W    = cnt_width(GAP_CYCLES);
    localparam int unsigned SETTLE_W = cnt_width(SETTLE_CYCLES);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || SETTLE_CYCLES < 1 ||
        GAP_CYCLES < 1 || MAX_TENURE < 1) begin : g_bad_cfg
        $error("ext_bus_master_arbiter: parameter out of range");
    end

    ext_arb_state_t         state_q, state_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [SETTLE_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [IDX_W-1:0]       pointer_q, pointer_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   ext_req_q, ext_req_d;

    logic                   bus_free;
    logic [NUM_MASTERS-1:0] arb_mask;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;

`ifdef EXT_BUS_ARB_TIMEOUT_EN
    localparam int unsigned TEN_W = cnt_width(MAX_TENURE);

    logic [TEN_W-1:0]       tenure_q, tenure_d;
    logic [NUM_MASTERS-1:0] mask_q, mask_d;
    logic                   timeout_pulse_q, timeout_pulse_d;

    assign arb_mask      = mask_q;
    assign timeout_pulse = timeout_pulse_q;
`else
    assign arb_mask      = '0;
    assign timeout_pulse = 1'b0;
`endif

    assign bus_free = address_enable_n & (&dma_acknowledge_n);

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req           (req),
        .mask          (arb_mask),
        .pointer       (pointer_q),
        .winner_onehot (pick_onehot),
        .winner_idx    (pick_idx),
        .valid         (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        settle_cnt_d = settle_cnt_q;
        pointer_d    = pointer_q;
        grant_d      = grant_q;
        ext_req_d    = ext_req_q;
`ifdef EXT_BUS_ARB_TIMEOUT_EN
        tenure_d        = tenure_q;
        // A timed-out master stays masked until its request is seen low.
        mask_d          = mask_q & req;
        timeout_pulse_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (gap_cnt_q != GAP_W'(GAP_CYCLES)) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
                if ((gap_cnt_q == GAP_W'(GAP_CYCLES)) && (|req)) begin
                    state_d      = StRequest;
                    ext_req_d    = 1'b1;
                    settle_cnt_d = '0;
                end
            end
            StRequest: begin
                if (!bus_free) begin
                    settle_cnt_d = '0;
                end else if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    if (pick_valid) begin
                        state_d   = StGrant;
                        grant_d   = pick_onehot;
                        pointer_d = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 :
                                    pick_idx + 1'b1;
`ifdef EXT_BUS_ARB_TIMEOUT_EN
                        tenure_d  = '0;
`endif
                    end else begin
                        state_d = StRelease;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            StGrant: begin
                if (!(|(grant_q & req))) begin
                    state_d = StRelease;
                    grant_d = '0;
                end
`ifdef EXT_BUS_ARB_TIMEOUT_EN
                else if (tenure_q == TEN_W'(MAX_TENURE - 1)) begin
                    state_d         = StRelease;
                    grant_d         = '0;
                    timeout_pulse_d = 1'b1;
                    mask_d          = mask_d | grant_q;
                end else begin
                    tenure_d = tenure_q + 1'b1;
                end
`endif
            end
            StRelease: begin
                if (no_command_state) begin
                    state_d   = StIdle;
                    ext_req_d = 1'b0;
                    gap_cnt_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            gap_cnt_q    <= GAP_W'(GAP_CYCLES);
            settle_cnt_q <= '0;
            pointer_q    <= '0;
            grant_q      <= '0;
            ext_req_q    <= 1'b0;
`ifdef EXT_BUS_ARB_TIMEOUT_EN
            tenure_q        <= '0;
            mask_q          <= '0;
            timeout_pulse_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            pointer_q    <= pointer_d;
            grant_q      <= grant_d;
            ext_req_q    <= ext_req_d;
`ifdef EXT_BUS_ARB_TIMEOUT_EN
            tenure_q        <= tenure_d;
            mask_q          <= mask_d;
            timeout_pulse_q <= timeout_pulse_d;
`endif
        end
    end

    assign grant              = grant_q;
    assign ext_access_request = ext_req_q;
    assign bus_owned          = |grant_q;

endmodule

// File: tb/tb_ext_bus_master_arbiter.sv
// Self-checking bench for ext_bus_master_arbiter: directed cases plus randomized traffic
// compared every cycle against a behavioural model.
module tb_ext_bus_master_arbiter;

    localparam int N      = 4;
    localparam int SETTLE = 2;
    localparam int GAP    = 8;
    localparam int MAXT   = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req   = '0;
    logic         aen   = 1'b1;
    logic [3:0]   dack  = 4'hF;
    logic         ncs   = 1'b1;
    logic [N-1:0] grant;
    logic         ext_req;
    logic         bus_owned;
    logic         timeout_pulse;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [N-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    always #5 clock = ~clock;

    ext_bus_master_arbiter #(
        .NUM_MASTERS   (N),
        .SETTLE_CYCLES (SETTLE),
        .GAP_CYCLES    (GAP),
        .MAX_TENURE    (MAXT)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .req                (req),
        .address_enable_n   (aen),
        .dma_acknowledge_n  (dack),
        .no_command_state   (ncs),
        .grant              (grant),
        .ext_access_request (ext_req),
        .bus_owned          (bus_owned),
        .timeout_pulse      (timeout_pulse)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: hold request, owner index, draining flag and a few counters.
    bit           m_hold  = 1'b0;
    bit           m_drain = 1'b0;
    bit           m_pulse = 1'b0;
    int           m_owner = -1;
    int           m_since = GAP;
    int           m_run   = 0;
    int           m_ptr   = 0;
    int           m_ten   = 0;
    logic [N-1:0] m_mask  = '0;

    task automatic model_reset();
        m_hold  = 1'b0;
        m_drain = 1'b0;
        m_pulse = 1'b0;
        m_owner = -1;
        m_since = GAP;
        m_run   = 0;
        m_ptr   = 0;
        m_ten   = 0;
        m_mask  = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] old_mask;
        bit           free;
        int           win;
        int           c;
        old_mask = m_mask;
        free     = aen && (dack == 4'hF);
        win      = -1;
        m_pulse  = 1'b0;
`ifdef EXT_BUS_ARB_TIMEOUT_EN
        m_mask = m_mask & req;
`endif
        if (!m_hold) begin
            if (m_since >= GAP && req != '0) begin
                m_hold = 1'b1;
                m_run  = 0;
            end else if (m_since < GAP) begin
                m_since++;
            end
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1;
                m_drain = 1'b1;
            end
`ifdef EXT_BUS_ARB_TIMEOUT_EN
            else begin
                m_ten++;
                if (m_ten == MAXT) begin
                    m_mask[m_owner] = 1'b1;
                    m_owner = -1;
                    m_drain = 1'b1;
                    m_pulse = 1'b1;
                end
            end
`endif
        end else if (m_drain) begin
            if (ncs) begin
                m_hold  = 1'b0;
                m_drain = 1'b0;
                m_since = 0;
            end
        end else begin
            m_run = free ? m_run + 1 : 0;
            if (m_run == SETTLE) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (win < 0 && req[c] && !old_mask[c]) win = c;
                end
                if (win >= 0) begin
                    m_owner = win;
                    m_ptr   = (win + 1) % N;
                    m_ten   = 0;
                end else begin
                    m_drain = 1'b1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    always @(negedge clock) begin : cmp
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        if (chk_en) begin
            check("grant", grant, eg);
            check("ext_access_request", ext_req, m_hold);
            check("bus_owned", bus_owned, |eg);
            check("timeout_pulse", timeout_pulse, m_pulse);
            check("grant_onehot0", $onehot0(grant), 1);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check("rst_grant", grant, 0);
        check("rst_req", ext_req, 0);
        check("rst_owned", bus_owned, 0);
        check("rst_pulse", timeout_pulse, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int budget);
        int n;
        n = 0;
        while (grant == '0 && n < budget) begin
            tick();
            n++;
        end
        check("wait_grant_in_budget", (grant != '0), 1);
    endtask

    initial begin
        int           cnt;
        logic [N-1:0] w;
        chk_en = 1'b1;
        #1;
        pulse_reset();

        // Single request: request after one edge, grant after 1+SETTLE edges.
        req = 4'b0010;
        tick();
        check("t1_req_up", ext_req, 1);
        check("t1_grant_early", grant, 0);
        tick();
        check("t1_grant_settling", grant, 0);
        tick();
        check("t1_grant", grant, 4'b0010);
        check("t1_owned", bus_owned, 1);
        req = '0;
        tick();
        check("t1_grant_drop", grant, 0);
        check("t1_req_held", ext_req, 1);
        tick();
        check("t1_req_low", ext_req, 0);

        // Round-robin order with all masters requesting.
        pulse_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(40);
            check("rr_order", grant, rr_exp[i]);
            w = grant;
            repeat (10) tick();
            req = req & ~w;
            tick();
            req = req | w;
        end
        req = '0;
        repeat (4) tick();

        // Broken bus-free runs keep the grant off.
        pulse_reset();
        req = 4'b0001;
        tick();
        for (int i = 0; i < 8; i++) begin
            aen = (i % 2 == 0);
            tick();
            check("t3_toggle_nogrant", grant, 0);
        end
        aen = 1'b1;
        tick();
        check("t3_one_free", grant, 0);
        tick();
        check("t3_grant", grant, 4'b0001);

        // DMA acknowledge blocks the grant for five clocks.
        pulse_reset();
        tick();
        check("t3b_req_up", ext_req, 1);
        dack = 4'b1110;
        repeat (5) begin
            tick();
            check("t3b_dma_nogrant", grant, 0);
        end
        dack = 4'hF;
        tick();
        check("t3b_one_free", grant, 0);
        tick();
        check("t3b_grant", grant, 4'b0001);

        // Release held by an active command; then gap before the next request.
        ncs = 1'b0;
        req = '0;
        tick();
        check("t4_grant_drop", grant, 0);
        repeat (5) begin
            tick();
            check("t4_req_held", ext_req, 1);
        end
        ncs = 1'b1;
        tick();
        check("t4_req_low", ext_req, 0);
        req = 4'b0001;
        cnt = 0;
        while (ext_req == 1'b0 && cnt < 40) begin
            tick();
            cnt++;
        end
        check("t4_gap_min", (cnt >= GAP && ext_req == 1'b1), 1);

        // Reset mid-tenure; pointer returns to 0.
        wait_grant(20);
        check("t5_pre_grant", grant, 4'b0001);
        req = 4'b1111;
        tick();
        pulse_reset();
        wait_grant(20);
        check("t5_ptr_restored", grant, 4'b0001);
        req = '0;
        repeat (3) tick();

`ifdef EXT_BUS_ARB_TIMEOUT_EN
        // Forced release after MAX_TENURE; the offender is skipped until it drops.
        pulse_reset();
        req = 4'b0010;
        wait_grant(20);
        req = 4'b0110;
        cnt = 1;
        while (grant == 4'b0010 && cnt < 100) begin
            tick();
            if (grant == 4'b0010) cnt++;
        end
        check("to_tenure_len", cnt, MAXT);
        check("to_pulse", timeout_pulse, 1);
        tick();
        check("to_pulse_once", timeout_pulse, 0);
        wait_grant(40);
        check("to_next_winner", grant, 4'b0100);
        req = '0;
        repeat (4) tick();
`endif

        // Randomized traffic checked by the model every cycle.
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
            end
            aen  = ($urandom_range(0, 7) != 0);
            dack = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            ncs  = ($urandom_range(0, 3) != 0);
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
